// File: rtl/mem_stream_reader.sv
// mem_stream_reader: read-port controller streaming words out of the frame memory.
// Optional MEM_RD_LAST_EN adds the out_last port and per-entry last flags.
module mem_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int RAM_DEPTH  = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef MEM_RD_LAST_EN
  ,
  output logic                  out_last
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX =
    ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_data [3];
  logic [1:0]            wr_ptr_q;
  logic [1:0]            rd_ptr_q;
  logic [1:0]            cnt_q;
  logic                  credit;
  logic                  last_issue;
  logic                  capture;
  logic                  pop;
  logic                  take;

  // Credit counts the word in flight so the 3-entry FIFO never overflows.
  assign credit     = ({1'b0, cnt_q} + {2'b0, inflight_q}) < 3'd3;
  assign last_issue = rem_q == LEN_WIDTH'(1);
  assign capture    = inflight_q;
  assign out_valid  = cnt_q != 2'd0;
  assign out_data   = fifo_data[rd_ptr_q];
  assign pop        = out_valid && out_ready;
  assign raddr      = addr_q;
  assign take       = (state_q == IDLE) && start && (len != '0);

  // State register.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and read/status outputs; DRAIN looks ahead at the final pop.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    done    = 1'b0;
    busy    = state_q != IDLE;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (len == '0) ? DONE : READ;
      end
      READ: begin
        if (credit) begin
          rd_en = 1'b1;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q &&
            (cnt_q == 2'd0 ||
             (cnt_q == 2'd1 && pop)))
          state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/remaining counters and the read-latency tracker.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (take) begin
        addr_q <= start_addr;
        rem_q  <= len;
      end else if (rd_en) begin
        addr_q <= (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

  // Output FIFO: capture the word returning from memory, pop on handshake.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < 3; i++) fifo_data[i] <= '0;
    end else begin
      if (capture) begin
        fifo_data[wr_ptr_q] <= rdata;
        wr_ptr_q <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop)
        rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      unique case ({capture, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef MEM_RD_LAST_EN
  logic       inflight_last_q;
  logic [2:0] fifo_last;

  assign out_last = out_valid && fifo_last[rd_ptr_q];

  // Last flag travels with its word through the read latency and FIFO.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_last_q <= 1'b0;
      fifo_last       <= '0;
    end else begin
      inflight_last_q <= rd_en && last_issue;
      if (capture) fifo_last[wr_ptr_q] <= inflight_last_q;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: directed scenarios against a preloaded 4-word memory.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_stream_reader;

  logic       clk;
  logic       rd_rst;
  logic       start;
  logic [1:0] start_addr;
  logic [2:0] len;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [1:0] raddr;
  logic [7:0] rdata;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef MEM_RD_LAST_EN
  logic       out_last;
`endif

  logic [7:0] mem [4];

  int n_tests;
  int n_fail;

  int words[$];
  int wcyc[$];
  int raddrs[$];
  int rdcyc[$];
  int lastflags[$];
  int done_cyc;
  int n_done;
  int busy_low;
  int n_valid;
  int hold_bad;
  int v_hi;
  int d_hi;
  int n_last;
  int last_bad;

  mem_stream_reader #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2),
    .RAM_DEPTH (4),
    .LEN_WIDTH (3)
  ) dut (
    .rd_clk    (clk),
    .rd_rst    (rd_rst),
    .start     (start),
    .start_addr(start_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef MEM_RD_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
    rdata = 8'h00;
  end

  always @(posedge clk) if (rd_en) rdata <= mem[raddr];

  // Run one transfer; cycle 0 is the start cycle. Records what it sees.
  task automatic run(input int a, input int l,
                     input int s_lo, input int s_hi,
                     input int again);
    int  c;
    bit  pstall;
    logic [7:0] pdata;
    words.delete(); wcyc.delete();
    raddrs.delete(); rdcyc.delete();
    lastflags.delete();
    done_cyc = -1; n_done = 0; busy_low = -1;
    n_valid = 0; hold_bad = 0; v_hi = -1; d_hi = -1;
    n_last = 0; last_bad = 0;
    pstall = 0; pdata = 0;
    @(negedge clk);
    start = 1; start_addr = 2'(a); len = 3'(l);
    out_ready = 1;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == again);
      start_addr = (c == again) ? 2'd3 : 2'd0;
      len = (c == again) ? 3'd2 : 3'd0;
      out_ready = !(c >= s_lo && c <= s_hi);
      if (rd_en) begin
        raddrs.push_back(int'(raddr));
        rdcyc.push_back(c);
      end
      if (out_valid) n_valid++;
      if (pstall && (!out_valid || out_data !== pdata))
        hold_bad++;
      if (c == s_hi) begin
        v_hi = int'(out_valid);
        d_hi = int'(out_data);
      end
`ifdef MEM_RD_LAST_EN
      if (out_last) begin
        n_last++;
        if (out_data !== 8'h12) last_bad++;
      end
`endif
      if (out_valid && out_ready) begin
        words.push_back(int'(out_data));
        wcyc.push_back(c);
`ifdef MEM_RD_LAST_EN
        lastflags.push_back(int'(out_last));
`endif
      end
      pstall = out_valid && !out_ready;
      pdata = out_data;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (!busy) begin
        busy_low = c;
        break;
      end
    end
    start = 0;
    out_ready = 1;
  endtask

  task automatic test_reset;
    rd_rst = 1; start = 0; start_addr = 0;
    len = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, rd_en, raddr, out_valid, out_data} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 0",
               {busy, done, rd_en, raddr, out_valid, out_data});
    end
    rd_rst = 0;
  endtask

  task automatic test_basic;
    int exp_w[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    run(0, 4, -1, -1, -1);
    n_tests++;
    if (words.size() !== 4) begin
      n_fail++;
      $display("FAIL basic_count got %0d exp 4", words.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (words[i] !== exp_w[i] || wcyc[i] !== 3 + i) begin
          n_fail++;
          $display("FAIL basic_word%0d got %h@%0d exp %h@%0d",
                   i, words[i], wcyc[i], exp_w[i], 3 + i);
        end
      end
    end
    n_tests++;
    if (rdcyc.size() !== 4 || rdcyc[0] !== 1) begin
      n_fail++;
      $display("FAIL basic_rden got %0d issues exp 4 from cycle 1",
               rdcyc.size());
    end
    n_tests++;
    if (done_cyc !== 7 || n_done !== 1) begin
      n_fail++;
      $display("FAIL basic_done got %0d (x%0d) exp 7 (x1)",
               done_cyc, n_done);
    end
    n_tests++;
    if (busy_low !== 8) begin
      n_fail++;
      $display("FAIL basic_busy_low got %0d exp 8", busy_low);
    end
  endtask

  task automatic test_wrap;
    int exp_w[6] = '{8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
    int exp_a[6] = '{2, 3, 0, 1, 2, 3};
    run(2, 6, -1, -1, -1);
    n_tests++;
    if (words.size() !== 6 || raddrs.size() !== 6) begin
      n_fail++;
      $display("FAIL wrap_count got %0d/%0d exp 6/6",
               words.size(), raddrs.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (words[i] !== exp_w[i] || raddrs[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL wrap_%0d got %h a%0d exp %h a%0d",
                   i, words[i], raddrs[i], exp_w[i], exp_a[i]);
        end
      end
    end
    n_tests++;
    if (done_cyc !== 9 || busy_low !== 10) begin
      n_fail++;
      $display("FAIL wrap_done got %0d/%0d exp 9/10",
               done_cyc, busy_low);
    end
  endtask

  task automatic test_backpressure;
    int exp_c[4] = '{9, 10, 11, 12};
    int early;
    run(0, 4, 3, 8, -1);
    early = 0;
    foreach (rdcyc[i]) if (rdcyc[i] <= 8) early++;
    n_tests++;
    if (early !== 3) begin
      n_fail++;
      $display("FAIL bp_issues got %0d exp 3", early);
    end
    n_tests++;
    if (v_hi !== 1 || d_hi !== 8'h10 || hold_bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold got v%0d d%h bad%0d exp v1 d10 bad0",
               v_hi, d_hi, hold_bad);
    end
    n_tests++;
    if (words.size() !== 4) begin
      n_fail++;
      $display("FAIL bp_count got %0d exp 4", words.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (words[i] !== 8'h10 + i || wcyc[i] !== exp_c[i]) begin
          n_fail++;
          $display("FAIL bp_word%0d got %h@%0d exp %h@%0d",
                   i, words[i], wcyc[i], 8'h10 + i, exp_c[i]);
        end
      end
    end
    n_tests++;
    if (done_cyc !== 13 || busy_low !== 14) begin
      n_fail++;
      $display("FAIL bp_done got %0d/%0d exp 13/14",
               done_cyc, busy_low);
    end
  endtask

  task automatic test_len_zero;
    run(1, 0, -1, -1, -1);
    n_tests++;
    if (done_cyc !== 1 || busy_low !== 2) begin
      n_fail++;
      $display("FAIL len0_done got %0d/%0d exp 1/2",
               done_cyc, busy_low);
    end
    n_tests++;
    if (rdcyc.size() !== 0 || n_valid !== 0) begin
      n_fail++;
      $display("FAIL len0_quiet got rd%0d v%0d exp 0/0",
               rdcyc.size(), n_valid);
    end
  endtask

  task automatic test_start_while_busy;
    run(0, 4, -1, -1, 3);
    n_tests++;
    if (words.size() !== 4) begin
      n_fail++;
      $display("FAIL busystart_count got %0d exp 4", words.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (words[i] !== 8'h10 + i) begin
          n_fail++;
          $display("FAIL busystart_word%0d got %h exp %h",
                   i, words[i], 8'h10 + i);
        end
      end
    end
    n_tests++;
    if (done_cyc !== 7 || n_done !== 1 || busy_low !== 8) begin
      n_fail++;
      $display("FAIL busystart_done got %0d x%0d/%0d exp 7 x1/8",
               done_cyc, n_done, busy_low);
    end
  endtask

  task automatic test_mid_reset;
    int dn;
    @(negedge clk);
    start = 1; start_addr = 0; len = 4; out_ready = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 0;
      rd_rst = (c == 4);
    end
    @(negedge clk);
    rd_rst = 0;
    n_tests++;
    if ({busy, done, rd_en, raddr, out_valid, out_data} !== 13'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got %b exp 0",
               {busy, done, rd_en, raddr, out_valid, out_data});
    end
    dn = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || out_valid) dn++;
    end
    n_tests++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL midrst_quiet got %0d exp 0", dn);
    end
    run(1, 1, -1, -1, -1);
    n_tests++;
    if (words.size() !== 1 || words[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL midrst_restart got n%0d w%h exp n1 w11",
               words.size(), (words.size() > 0) ? words[0] : -1);
    end
    n_tests++;
    if (done_cyc !== 4) begin
      n_fail++;
      $display("FAIL midrst_done got %0d exp 4", done_cyc);
    end
  endtask

`ifdef MEM_RD_LAST_EN
  task automatic test_last;
    run(0, 3, 5, 7, -1);
    n_tests++;
    if (n_last !== 4 || last_bad !== 0) begin
      n_fail++;
      $display("FAIL last_cycles got %0d bad%0d exp 4 bad0",
               n_last, last_bad);
    end
    n_tests++;
    if (lastflags.size() !== 3 ||
        lastflags[0] !== 0 || lastflags[1] !== 0 ||
        lastflags[2] !== 1) begin
      n_fail++;
      $display("FAIL last_flags got n%0d exp 0,0,1",
               lastflags.size());
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_while_busy();
    test_mid_reset();
`ifdef MEM_RD_LAST_EN
    test_last();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read-side controller for the dual-clock line/frame memory. It sits in the memory's read clock domain and owns that domain's read port. It drives `raddr` and `rd_en` from a start address and word count, and absorbs the memory's one-cycle registered read latency. Data is delivered as a valid/ready pixel stream with full backpressure, to downstream image-processing stages.

## Interface
- `DATA_WIDTH`, 8: pixel/word width; matches the memory's `DATA_WIDTH`.
- `ADDR_WIDTH`, 2: memory address width.
- `RAM_DEPTH`, 4: number of memory words; need not be a power of two.
- `LEN_WIDTH`, `ADDR_WIDTH+1`: width of the transfer-length port.

Ports:
- `rd_clk`  in  1  the single clock. Same clock as the memory's `rd_clk`.
- `rd_rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request pulse; sampled only in IDLE.
- `start_addr`  in  ADDR_WIDTH  first word address; must be < RAM_DEPTH.
- `len`  in  LEN_WIDTH  number of words to read.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rd_en`  out  1  memory read enable.
- `raddr`  out  ADDR_WIDTH  memory read address.
- `rdata`  in  DATA_WIDTH  memory read data, valid the cycle after `rd_en`.
- `out_valid`  out  1  stream data valid.
- `out_ready`  in  1  stream sink ready.
- `out_data`  out  DATA_WIDTH  stream data.
- `out_last`  out  1  final word marker; present only with `MEM_RD_LAST_EN`.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- **IDLE**
  - `start`=1, `len`>0: latch `start_addr` into the address counter and `len` into the remaining counter, then go to READ.
  - `start`=1, `len`=0: go to DONE.
- **READ**
  - Assert `rd_en` with `raddr` = address counter whenever `occupancy + inflight < 3`. The credit check uses registered values only. There is no combinational path from `out_ready` to `rd_en`.
  - Each issue increments the address. The address wraps from RAM_DEPTH-1 to 0. Each issue decrements remaining.
  - The issue that brings remaining to 0 moves the FSM to DRAIN.
- **DRAIN**: no reads. Go to DONE when the buffer is empty and nothing is in flight.
- **DONE**: `done`=1 for one cycle, then go to IDLE. `busy` stays high in DONE.
- **Buffer**
  - A 3-entry output FIFO captures `rdata` in the cycle after each issue (`inflight`=1).
  - `out_data`/`out_valid` come from the FIFO head, registered.
  - A word pops on `out_valid && out_ready`.
  - Simultaneous capture and pop leaves occupancy unchanged.
- `len` > RAM_DEPTH is legal: addresses keep wrapping and words are re-read in order.
- `start` while `busy` is ignored. Latched parameters do not change mid-transfer.
- `rd_rst` asserted mid-transfer:
  - Next cycle: FSM in IDLE, FIFO flushed, in-flight word discarded.
  - No `done` pulse is produced.
- When `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable.

## Timing
- Reset value of every output is 0: `busy`, `done`, `rd_en`, `raddr`, `out_valid`, `out_data`, `out_last`.
- Cycle numbering: `start` is sampled in cycle 0.
- Normal transfer:
  - First `rd_en` in cycle 1.
  - `rdata` valid in cycle 2 and captured at the end of cycle 2.
  - First `out_valid` in cycle 3.
- With `out_ready`=1 throughout, throughput is one word per cycle. For `len`=N:
  - words appear on cycles 3..N+2;
  - `done` is high in cycle N+3;
  - `busy` is low from cycle N+4.
- `len`=0: `done` in cycle 1, `busy` low from cycle 2, no `rd_en`, no `out_valid`.
- `done` always follows the final stream handshake by exactly one cycle.

## Configuration
- `MEM_RD_LAST_EN` defined:
  - `out_last` port exists.
  - Each FIFO entry carries a last flag, set on the word whose issue brought remaining to 0.
  - `out_last`=1 only while that word is presented.
- `MEM_RD_LAST_EN` undefined: no `out_last` port and no flag storage. All other behaviour is identical.

## Test plan
In all scenarios, memory is preloaded with mem[i]=0x10+i and RAM_DEPTH=4.
- `start_addr`=0, `len`=4, `out_ready`=1 -> `out_data` 0x10,0x11,0x12,0x13 on cycles 3–6; `done` on cycle 7; `busy` low on cycle 8.
- `start_addr`=2, `len`=6 -> stream 0x12,0x13,0x10,0x11,0x12,0x13; `raddr` wraps 3->0.
- `start_addr`=0, `len`=4, `out_ready`=0 during cycles 3–8:
  - `out_data` holds 0x10 with `out_valid`=1;
  - `rd_en` stops after 3 issues;
  - after release, the stream is 0x10–0x13 in order with no loss or duplicates.
- `len`=0 -> `done`=1 in cycle 1; `rd_en` and `out_valid` never assert.
- `start` pulsed while busy -> ignored and the stream is unchanged.
- `rd_rst` pulsed in cycle 4 of a 4-word transfer:
  - next cycle, all outputs are 0 and there is no `done`;
  - a new start with `start_addr`=1, `len`=1 yields 0x11.
- With `MEM_RD_LAST_EN`: `len`=3 -> `out_last`=1 only with the third word 0x12, including when that word is stalled by `out_ready`=0.
